// File: rtl/key_event_ctrl_pkg.sv
// Shared types and constants for the key-event controller.
// Timer depth defaults target a 100 MHz system clock.
package key_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS1,
    ST_WAIT2,
    ST_PRESS2,
    ST_LONG
  } state_e;

  localparam int unsigned LONG_CNT_DEF   = 200_000_000;
  localparam int unsigned REPEAT_CNT_DEF = 20_000_000;
  localparam int unsigned DOUBLE_CNT_DEF = 30_000_000;
  localparam int unsigned CNT_W_DEF      = 28;

  // Debouncer reports a pressed key as a low level.
  localparam logic KEY_PRESSED = 1'b0;

endpackage

// File: rtl/key_event_ctrl_if.sv
// Debouncer-facing inputs and user-event outputs of the key-event controller.
// The master side is the debouncer/consumer pair; the slave side is the controller.
interface key_event_ctrl_if;
  logic key_flag;
  logic key_value;
  logic short_press;
  logic double_press;
  logic long_press;
  logic repeat_press;
  logic key_held;

  modport master (
    output key_flag, key_value,
    input  short_press, double_press, long_press, repeat_press, key_held
  );

  modport slave (
    input  key_flag, key_value,
    output short_press, double_press, long_press, repeat_press, key_held
  );
endinterface

// File: rtl/key_event_ctrl_event_timer.sv
// Free-running gesture timer with synchronous clear.
// Flags the last cycle of each of the three gesture intervals.
module event_timer
  import key_event_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
  parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF,
  parameter int unsigned DOUBLE_CNT = DOUBLE_CNT_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  output logic long_exp,
  output logic rep_exp,
  output logic dbl_exp
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign long_exp = (cnt_q == CNT_W'(LONG_CNT - 1));
  assign rep_exp  = (cnt_q == CNT_W'(REPEAT_CNT - 1));
  assign dbl_exp  = (cnt_q == CNT_W'(DOUBLE_CNT - 1));

endmodule

// File: rtl/key_event_ctrl.sv
// Classifies debounced key activity into short, double, long and auto-repeat
// event pulses. All event outputs are registered one-cycle pulses.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
  parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF,
  parameter int unsigned DOUBLE_CNT = DOUBLE_CNT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  key_event_ctrl_if.slave  bus
);

  state_e state_q, state_d;
  logic   short_q,  short_d;
  logic   double_q, double_d;
  logic   long_q,   long_d;
  logic   repeat_q, repeat_d;
  logic   rep_clr;
  logic   timer_clr;
  logic   long_exp, rep_exp, dbl_exp;
  logic   press, release_ev;

  assign press      = bus.key_flag && (bus.key_value == KEY_PRESSED);
  assign release_ev = bus.key_flag && (bus.key_value != KEY_PRESSED);

  event_timer #(
    .CNT_W      (CNT_W),
    .LONG_CNT   (LONG_CNT),
    .REPEAT_CNT (REPEAT_CNT),
    .DOUBLE_CNT (DOUBLE_CNT)
  ) u_timer (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .clr      (timer_clr),
    .long_exp (long_exp),
    .rep_exp  (rep_exp),
    .dbl_exp  (dbl_exp)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    rep_clr  = 1'b0;
    // Strobes are tested before expiries so a coincident key event wins;
    // a strobe matching the current key level falls through untouched.
    unique case (state_q)
      ST_IDLE: begin
        if (press) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (release_ev) begin
          state_d = ST_WAIT2;
        end else if (long_exp) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (press) begin
          state_d = ST_PRESS2;
        end else if (dbl_exp) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (release_ev) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end else if (long_exp) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end
      end
      ST_LONG: begin
        if (release_ev) begin
          state_d = ST_IDLE;
        end else if (rep_exp) begin
          repeat_d = 1'b1;
          rep_clr  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign timer_clr = (state_d != state_q) || rep_clr;

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
    end
  end

  assign bus.short_press  = short_q;
  assign bus.double_press = double_q;
  assign bus.long_press   = long_q;
  assign bus.repeat_press = repeat_q;
  assign bus.key_held     = (state_q == ST_PRESS1) || (state_q == ST_PRESS2) ||
                            (state_q == ST_LONG);

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
Key-event controller that sits directly behind the key debounce block and sequences its output into user-level events. It consumes the debounced strobe (key_flag) and level (key_value) and classifies each gesture as short press, double press, long press, or auto-repeat while held. Downstream mode/menu logic of the ranging system consumes only these one-cycle event pulses, never raw key levels.

Parameters:
LONG_CNT, 200_000_000, cycles a press must be held to count as long press (2 s at 100 MHz)
REPEAT_CNT, 20_000_000, cycles between auto-repeat pulses once in long-press hold (200 ms)
DOUBLE_CNT, 30_000_000, cycles after a short release within which a second press makes a double press (300 ms)
CNT_W, 28, timer width; must satisfy 2^CNT_W > max(LONG_CNT, REPEAT_CNT, DOUBLE_CNT)

Ports:
sys_clk  input  1  system clock (100 MHz)
sys_rst  input  1  reset, synchronous, active-high
key_flag  input  1  one-cycle strobe from debouncer: key_value is newly stable
key_value  input  1  debounced key level, 0 = pressed, 1 = released
short_press  output  1  one-cycle pulse: single short click confirmed
double_press  output  1  one-cycle pulse: two short clicks within DOUBLE_CNT
long_press  output  1  one-cycle pulse: hold reached LONG_CNT
repeat_press  output  1  one-cycle pulse every REPEAT_CNT while held after long_press
key_held  output  1  level: 1 while FSM is in PRESS1, PRESS2 or LONG

Behaviour:
- Reset: state=IDLE, timer=0, all outputs 0. Reset mid-gesture discards it; no pulse is emitted.
- "press" = key_flag && key_value==0; "release" = key_flag && key_value==1. key_value is ignored when key_flag=0.
- All outputs registered. A pulse is high the cycle after the deciding event/expiry cycle, for exactly one cycle.
- Timer: cleared on every state transition, else increments; "expiry of N" = timer==N-1 in current state.
- States/transitions:
  - IDLE: press -> PRESS1. A release is ignored.
  - PRESS1: release -> WAIT2. Expiry of LONG_CNT -> LONG, pulse long_press.
  - WAIT2: press -> PRESS2. Expiry of DOUBLE_CNT -> IDLE, pulse short_press.
  - PRESS2: release -> IDLE, pulse double_press. Expiry of LONG_CNT -> LONG, pulse long_press. The first click is discarded and no short_press is emitted.
  - LONG: every expiry of REPEAT_CNT pulses repeat_press and clears the timer (stays in LONG). Release -> IDLE with no pulse.
- Simultaneous key_flag and expiry in the same cycle: key_flag wins. The expiry action is not taken.
- A redundant strobe (press while pressed, release while released) is ignored; the timer is not cleared.
- At most one output pulse per cycle. Pulses are mutually exclusive by construction.
- A short click therefore reports DOUBLE_CNT cycles after release. This latency is intentional.

Decomposition:
- Package key_event_pkg:
  - state encoding typedef (IDLE, PRESS1, WAIT2, PRESS2, LONG)
  - default count constants
  - the key_value pressed-level constant (1'b0)
- One sub-module, event_timer: CNT_W-bit up-counter with synchronous clear and three terminal-compare outputs (long_exp, rep_exp, dbl_exp).
- The FSM and output registers stay in key_event_ctrl.

Test Plan:
Benches use LONG_CNT=100, REPEAT_CNT=20, DOUBLE_CNT=30.
1. Short click: press at t0, release at t0+10 -> single short_press at release_cycle+31. No other pulses. key_held high t0+1..t0+10.
2. Double click: press, release after 10, press after 5 more, release after 10 -> one double_press the cycle after the second release. No short_press.
3. Long hold 170 cycles: press at t0 -> long_press at t0+101. repeat_press at t0+121, t0+141, t0+161. Release gives no pulse; key_held drops the cycle after release.
4. Boundary: release strobe in the same cycle the LONG_CNT expiry would fire -> FSM goes to WAIT2, no long_press. A press strobe on the last WAIT2 cycle -> PRESS2, no short_press.
5. Redundant strobes: a second press strobe at PRESS1 timer=50 -> long_press still fires at t0+101 (timer not cleared). A release strobe in IDLE -> no output change.
6. Reset mid-gesture: assert sys_rst for 1 cycle in LONG and in WAIT2 -> all outputs 0 the next cycle, state IDLE, no pending short_press ever emitted.
